frame_parser_pgen: RTL and testbench
====================================

Name: frame_parser_pgen

Overview:
Single-clock, parametrised successor of the serial frame detector. It parses header / channel-word / payload / CRC / trailer frames from a DW-bit input stream and buffers the payload internally. It checks CRC16-CCITT and releases the payload on a valid/ready stream tagged with a multicast channel mask, optionally Gray-coded. Bad frames are dropped and flagged. It sits between the input capture stage and the per-channel serialisers.

Parameters:
DW, 16, data word width; must be at least NUM_CH+LEN_W.
NUM_CH, 8, number of output channels; width of the one-hot or multicast mask.
MAX_WORDS, 8, maximum payload length in DW-bit words.
LEN_W, $clog2(MAX_WORDS), width of the length field.
HEADER, 32'hE0E0E0E0, 2*DW-bit header, sent high word first.
TRAILER, 32'h0E0E0E0E, 2*DW-bit trailer, sent high word first.
GRAY_EN, 1, when 1, out_data is the Gray code of the payload word.
TIMEOUT, 64, maximum idle cycles (in_valid low) allowed mid-frame.

Ports:
clk_in  in  1  sole clock
rst  in  1  asynchronous reset, active-high
in_data  in  DW  input word, Big-Endian word order
in_valid  in  1  in_data qualifier
in_ready  out  1  block can accept a word
out_data  out  DW  payload word, Gray-coded if GRAY_EN
out_ch_mask  out  NUM_CH  destination channel mask of the current frame
out_valid  out  1  out_data valid
out_ready  in  1  downstream accepts word
out_last  out  1  final payload word of the frame
crc_ok  out  1  one-cycle pulse: frame accepted
crc_err  out  1  one-cycle pulse: CRC mismatch, frame dropped
fmt_err  out  1  one-cycle pulse: bad mask, bad trailer or timeout, frame dropped

Behaviour:
- Reset: FSM to IDLE; all outputs 0 except in_ready=1; buffer contents don't-care; CRC register = 16'h0000. Reset mid-frame or mid-drain discards everything with no pulses.
- A word is consumed only when in_valid && in_ready. in_ready=1 in every state except DRAIN.
- Channel word fields: mask = bits [NUM_CH-1:0]; len_m1 = bits [NUM_CH+LEN_W-1:NUM_CH]; payload length = len_m1+1 words.
- IDLE: word == HEADER[2DW-1:DW] -> HDR2.
- HDR2:
  - word == HEADER[DW-1:0] -> CHAN.
  - word == HEADER high half -> stay in HDR2 (resync).
  - any other word -> IDLE (silent, no pulse).
- CHAN: repeated HEADER low-half words are ignored. Otherwise latch mask and len_m1, clear CRC, clear word counter.
  - mask == 0 -> fmt_err, IDLE.
  - otherwise -> PAYLOAD.
- PAYLOAD: write word to buffer[cnt] and update CRC.
  - CRC is CRC16-CCITT: poly 0x1021, init 0x0000, MSB first, DW bits per cycle, no reflection, no final XOR.
  - cnt == len_m1 -> CRC state.
- CRC: compare the word with the CRC register and latch the result -> TRL1.
- TRL1 / TRL2: expect TRAILER high word then TRAILER low word. Any mismatch -> fmt_err, IDLE.
- After a correct TRL2 word:
  - CRC mismatch latched -> crc_err the next cycle, IDLE.
  - CRC matched -> crc_ok the next cycle, DRAIN.
- DRAIN: output buffer words 0..len_m1 in order.
  - out_valid is held; out_data and out_ch_mask stay stable until out_ready.
  - out_last=1 on word len_m1.
  - The handshake after the last word -> IDLE, with out_valid low on the next cycle.
  - Latency: first out_valid appears 1 cycle after crc_ok.
- Timeout: in states HDR2..TRL2, the idle counter increments on cycles with in_valid=0 and clears on each accepted word. Reaching TIMEOUT -> fmt_err, IDLE.
- Only one error pulse per frame; crc_ok, crc_err and fmt_err are mutually exclusive.
- Gray coding: out_data = w ^ (w>>1) when GRAY_EN=1, otherwise w.

Test Plan:
- Frame E0E0, E0E0, 0x0001, 0xA55A, crc(A55A), 0E0E, 0E0E -> crc_ok pulse; one output word F7F7 with out_ch_mask=0x01 and out_last=1.
- 8-word payload 0123…3210, mask 0x02, out_ready toggling 1/0 -> all 8 Gray words in order; data held stable while stalled; out_last only on word 8.
- Multicast mask 0x0C with 4 words, followed immediately by a second frame -> in_ready=0 during DRAIN; the second frame is parsed correctly after drain completes.
- Payload 0x1234 with CRC field 0xFFFF -> crc_err pulse, no out_valid; next valid frame passes.
- Mask 0x00 -> fmt_err. Trailer low word 0x0E0F -> fmt_err. in_valid held low for 64 cycles mid-payload -> fmt_err, FSM returns to IDLE.
- rst asserted during DRAIN -> out_valid=0 immediately; no pulses; next frame parses correctly.

Source files
------------

// File: rtl/frame_parser_pgen_if.sv
// Port bundle between the input capture stage, the frame parser and the
// per-channel serialisers. The parser is the slave; the environment is the master.
interface frame_parser_pgen_if #(
  parameter int DW     = 16,
  parameter int NUM_CH = 8
);
  logic [DW-1:0]     in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DW-1:0]     out_data;
  logic [NUM_CH-1:0] out_ch_mask;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
  logic              crc_ok;
  logic              crc_err;
  logic              fmt_err;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_ch_mask, out_valid, out_last,
           crc_ok, crc_err, fmt_err
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_ch_mask, out_valid, out_last,
           crc_ok, crc_err, fmt_err
  );
endinterface

// File: rtl/frame_parser_pgen.sv
// Frame parser: header / channel word / payload / CRC16-CCITT / trailer framing.
// Payload is buffered and released on a valid/ready stream only after the CRC passes.
module frame_parser_pgen #(
  parameter int              DW        = 16,
  parameter int              NUM_CH    = 8,
  parameter int              MAX_WORDS = 8,
  parameter int              LEN_W     = $clog2(MAX_WORDS),
  parameter logic [2*DW-1:0] HEADER    = 32'hE0E0E0E0,
  parameter logic [2*DW-1:0] TRAILER   = 32'h0E0E0E0E,
  parameter bit              GRAY_EN   = 1'b1,
  parameter int              TIMEOUT   = 64
) (
  input logic                clk_in,
  input logic                rst,
  frame_parser_pgen_if.slave bus
);

  localparam int            IDLE_W = $clog2(TIMEOUT + 1);
  localparam logic [DW-1:0] HDR_HI = HEADER[2*DW-1:DW];
  localparam logic [DW-1:0] HDR_LO = HEADER[DW-1:0];
  localparam logic [DW-1:0] TRL_HI = TRAILER[2*DW-1:DW];
  localparam logic [DW-1:0] TRL_LO = TRAILER[DW-1:0];

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HDR2    = 3'd1,
    ST_CHAN    = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_CRC     = 3'd4,
    ST_TRL1    = 3'd5,
    ST_TRL2    = 3'd6,
    ST_DRAIN   = 3'd7
  } state_t;

  state_t              state_r;
  state_t              state_nx_s;
  logic                accept_s;
  logic                out_hs_s;
  logic                timeout_s;
  logic                fmt_err_s;
  logic                crc_ok_s;
  logic                crc_err_s;
  logic [NUM_CH-1:0]   chan_mask_s;
  logic [LEN_W-1:0]    chan_len_s;

  logic                in_ready_r;
  logic [NUM_CH-1:0]   mask_r;
  logic [LEN_W-1:0]    len_m1_r;
  logic [LEN_W-1:0]    cnt_r;
  logic [LEN_W-1:0]    rd_cnt_r;
  logic [15:0]         crc_r;
  logic                crc_match_r;
  logic [IDLE_W-1:0]   idle_cnt_r;
  logic [DW-1:0]       buf_r [MAX_WORDS];
  logic [DW-1:0]       out_data_r;
  logic [NUM_CH-1:0]   out_ch_mask_r;
  logic                out_valid_r;
  logic                out_last_r;
  logic                crc_ok_r;
  logic                crc_err_r;
  logic                fmt_err_r;

  // CRC16-CCITT (poly 0x1021), MSB first, one DW-bit word per call
  function automatic logic [15:0] crc16_upd(input logic [15:0] crc, input logic [DW-1:0] d);
    logic [15:0] c;
    logic        fb;
    c = crc;
    for (int i = DW - 1; i >= 0; i--) begin
      fb = c[15] ^ d[i];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction

  function automatic logic [DW-1:0] out_code(input logic [DW-1:0] w);
    if (GRAY_EN) begin
      return w ^ (w >> 1);
    end else begin
      return w;
    end
  endfunction

  assign accept_s    = bus.in_valid && in_ready_r;
  assign out_hs_s    = out_valid_r && bus.out_ready;
  assign timeout_s   = !bus.in_valid && (idle_cnt_r == IDLE_W'(TIMEOUT - 1));
  assign chan_mask_s = bus.in_data[NUM_CH-1:0];
  assign chan_len_s  = bus.in_data[NUM_CH+LEN_W-1:NUM_CH];

  // Next-state decode and one-cycle status requests
  always_comb begin
    state_nx_s = state_r;
    fmt_err_s  = 1'b0;
    crc_ok_s   = 1'b0;
    crc_err_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s && bus.in_data == HDR_HI) begin
          state_nx_s = ST_HDR2;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        if (out_hs_s && out_last_r) begin
          state_nx_s = ST_IDLE;
        end else begin
          state_nx_s = ST_DRAIN;
        end
      end
      default: begin
        if (timeout_s) begin
          state_nx_s = ST_IDLE;
          fmt_err_s  = 1'b1;
        end else if (accept_s) begin
          case (state_r)
            ST_HDR2: begin
              if (bus.in_data == HDR_LO) begin
                state_nx_s = ST_CHAN;
              end else if (bus.in_data == HDR_HI) begin
                state_nx_s = ST_HDR2;
              end else begin
                state_nx_s = ST_IDLE;
              end
            end
            ST_CHAN: begin
              if (bus.in_data == HDR_LO) begin
                state_nx_s = ST_CHAN;
              end else if (chan_mask_s == {NUM_CH{1'b0}}) begin
                state_nx_s = ST_IDLE;
                fmt_err_s  = 1'b1;
              end else begin
                state_nx_s = ST_PAYLOAD;
              end
            end
            ST_PAYLOAD: begin
              if (cnt_r == len_m1_r) begin
                state_nx_s = ST_CRC;
              end else begin
                state_nx_s = ST_PAYLOAD;
              end
            end
            ST_CRC: state_nx_s = ST_TRL1;
            ST_TRL1: begin
              if (bus.in_data == TRL_HI) begin
                state_nx_s = ST_TRL2;
              end else begin
                state_nx_s = ST_IDLE;
                fmt_err_s  = 1'b1;
              end
            end
            ST_TRL2: begin
              if (bus.in_data != TRL_LO) begin
                state_nx_s = ST_IDLE;
                fmt_err_s  = 1'b1;
              end else if (crc_match_r) begin
                state_nx_s = ST_DRAIN;
                crc_ok_s   = 1'b1;
              end else begin
                state_nx_s = ST_IDLE;
                crc_err_s  = 1'b1;
              end
            end
            default: state_nx_s = ST_IDLE;
          endcase
        end else begin
          state_nx_s = state_r;
        end
      end
    endcase
  end

  // State register, input handshake, status pulses and mid-frame idle counter
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      in_ready_r <= 1'b1;
      crc_ok_r   <= 1'b0;
      crc_err_r  <= 1'b0;
      fmt_err_r  <= 1'b0;
      idle_cnt_r <= {IDLE_W{1'b0}};
    end else begin
      state_r    <= state_nx_s;
      in_ready_r <= (state_nx_s != ST_DRAIN);
      crc_ok_r   <= crc_ok_s;
      crc_err_r  <= crc_err_s;
      fmt_err_r  <= fmt_err_s;
      if (state_nx_s == ST_IDLE || state_nx_s == ST_DRAIN || accept_s) begin
        idle_cnt_r <= {IDLE_W{1'b0}};
      end else if (!bus.in_valid) begin
        idle_cnt_r <= idle_cnt_r + IDLE_W'(1);
      end
    end
  end

  // Frame context: channel word fields, write pointer, running CRC and verdict
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      mask_r      <= {NUM_CH{1'b0}};
      len_m1_r    <= {LEN_W{1'b0}};
      cnt_r       <= {LEN_W{1'b0}};
      crc_r       <= 16'h0000;
      crc_match_r <= 1'b0;
    end else if (accept_s) begin
      case (state_r)
        ST_CHAN: begin
          if (bus.in_data != HDR_LO) begin
            mask_r   <= chan_mask_s;
            len_m1_r <= chan_len_s;
            cnt_r    <= {LEN_W{1'b0}};
            crc_r    <= 16'h0000;
          end
        end
        ST_PAYLOAD: begin
          crc_r <= crc16_upd(crc_r, bus.in_data);
          cnt_r <= cnt_r + LEN_W'(1);
        end
        ST_CRC:  crc_match_r <= (bus.in_data == DW'(crc_r));
        default: crc_match_r <= crc_match_r;
      endcase
    end
  end

  // Payload buffer; contents are don't-care after reset
  always_ff @(posedge clk_in) begin
    if (accept_s && state_r == ST_PAYLOAD) begin
      buf_r[cnt_r] <= bus.in_data;
    end
  end

  // Output stage: a word stays presented until the downstream handshake
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      out_data_r    <= {DW{1'b0}};
      out_ch_mask_r <= {NUM_CH{1'b0}};
      out_valid_r   <= 1'b0;
      out_last_r    <= 1'b0;
      rd_cnt_r      <= {LEN_W{1'b0}};
    end else if (state_r == ST_DRAIN) begin
      if (!out_valid_r || (bus.out_ready && !out_last_r)) begin
        out_data_r    <= out_code(buf_r[rd_cnt_r]);
        out_ch_mask_r <= mask_r;
        out_valid_r   <= 1'b1;
        out_last_r    <= (rd_cnt_r == len_m1_r);
        rd_cnt_r      <= rd_cnt_r + LEN_W'(1);
      end else if (bus.out_ready) begin
        out_valid_r <= 1'b0;
        out_last_r  <= 1'b0;
      end
    end else begin
      out_valid_r <= 1'b0;
      out_last_r  <= 1'b0;
      rd_cnt_r    <= {LEN_W{1'b0}};
    end
  end

  assign bus.in_ready    = in_ready_r;
  assign bus.out_data    = out_data_r;
  assign bus.out_ch_mask = out_ch_mask_r;
  assign bus.out_valid   = out_valid_r;
  assign bus.out_last    = out_last_r;
  assign bus.crc_ok      = crc_ok_r;
  assign bus.crc_err     = crc_err_r;
  assign bus.fmt_err     = fmt_err_r;

endmodule

// File: tb/tb_frame_parser_pgen.sv
// Scoreboard bench for frame_parser_pgen: stimulus pushes expected events,
// a negedge monitor pops and compares every pulse and output handshake.
module tb_frame_parser_pgen;

  localparam int EV_WORD = 0;
  localparam int EV_OK   = 1;
  localparam int EV_CERR = 2;
  localparam int EV_FERR = 3;

  typedef struct {
    int          kind;
    logic [15:0] data;
    logic [7:0]  mask;
    logic        last;
  } ev_t;

  logic        clk_in;
  logic        rst;
  ev_t         exp_q [$];
  int          errors = 0;
  int          checks = 0;
  int          ready_mode = 0;
  int          np_m;
  logic [15:0] pay [8];
  logic        stall_prev;
  logic [15:0] prev_data;
  logic [7:0]  prev_mask;
  logic        prev_last;

  frame_parser_pgen_if #(.DW(16), .NUM_CH(8)) bus ();

  frame_parser_pgen #(
    .DW(16), .NUM_CH(8), .MAX_WORDS(8), .GRAY_EN(1'b1), .TIMEOUT(64)
  ) dut (
    .clk_in(clk_in),
    .rst   (rst),
    .bus   (bus.slave)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  function automatic logic [15:0] gray_m(input logic [15:0] w);
    return w ^ {1'b0, w[15:1]};
  endfunction

  // XMODEM-style word update: fold the word in, then shift 16 times
  function automatic logic [15:0] crc_m(input logic [15:0] c, input logic [15:0] w);
    logic [15:0] r;
    r = c ^ w;
    for (int k = 0; k < 16; k++) begin
      if (r[15]) r = {r[14:0], 1'b0} ^ 16'h1021;
      else       r = {r[14:0], 1'b0};
    end
    return r;
  endfunction

  task automatic push_ev(input int kind, input logic [15:0] d, input logic [7:0] m, input logic l);
    ev_t e;
    e.kind = kind; e.data = d; e.mask = m; e.last = l;
    exp_q.push_back(e);
  endtask

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic check_event(input int kind, input logic [15:0] d, input logic [7:0] m, input logic l);
    ev_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL event: got kind %0d data %h mask %h, required no event", kind, d, m);
    end else begin
      e = exp_q.pop_front();
      if (e.kind != kind || (kind == EV_WORD && (e.data !== d || e.mask !== m || e.last !== l))) begin
        errors++;
        $display("FAIL event: got kind %0d data %h mask %h last %b, required kind %0d data %h mask %h last %b",
                 kind, d, m, l, e.kind, e.data, e.mask, e.last);
      end
    end
  endtask

  // Monitor: status pulses, output handshakes, stall stability, in_ready during drain
  always @(negedge clk_in) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      np_m = int'(bus.crc_ok) + int'(bus.crc_err) + int'(bus.fmt_err);
      if (np_m > 1) begin
        checks++; errors++;
        $display("FAIL pulses: got %0d simultaneous status pulses, required at most 1", np_m);
      end
      if (bus.crc_ok)  check_event(EV_OK,   16'h0000, 8'h00, 1'b0);
      if (bus.crc_err) check_event(EV_CERR, 16'h0000, 8'h00, 1'b0);
      if (bus.fmt_err) check_event(EV_FERR, 16'h0000, 8'h00, 1'b0);
      if (stall_prev) begin
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_data !== prev_data ||
            bus.out_ch_mask !== prev_mask || bus.out_last !== prev_last) begin
          errors++;
          $display("FAIL stall_hold: got valid %b data %h mask %h last %b, required 1 %h %h %b",
                   bus.out_valid, bus.out_data, bus.out_ch_mask, bus.out_last, prev_data, prev_mask, prev_last);
        end
      end
      if (bus.out_valid) begin
        checks++;
        if (bus.in_ready !== 1'b0) begin
          errors++;
          $display("FAIL drain_in_ready: got %b required 0", bus.in_ready);
        end
      end
      if (bus.out_valid && bus.out_ready) check_event(EV_WORD, bus.out_data, bus.out_ch_mask, bus.out_last);
      stall_prev = bus.out_valid && !bus.out_ready;
      prev_data  = bus.out_data;
      prev_mask  = bus.out_ch_mask;
      prev_last  = bus.out_last;
    end
  end

  // Downstream ready pattern: 0 = always ready, 1 = toggling, otherwise stalled
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk_in); #1;
      case (ready_mode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = ~bus.out_ready;
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  task automatic send_word(input logic [15:0] w);
    int n;
    n = 0;
    bus.in_data  = w;
    bus.in_valid = 1'b1;
    while (bus.in_ready !== 1'b1 && n < 200) begin
      @(posedge clk_in); #1;
      n++;
    end
    if (bus.in_ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL send_word: in_ready got %b required 1 within 200 cycles", bus.in_ready);
    end
    @(posedge clk_in); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk_in); #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] mask, input int n, input int extra_hdr,
                            input logic crc_bad, input logic [15:0] trl_lo);
    logic [15:0] crc;
    logic [15:0] crc_field;
    logic [2:0]  len3;
    crc = 16'h0000;
    for (int i = 0; i < n; i++) crc = crc_m(crc, pay[i]);
    crc_field = crc_bad ? 16'hFFFF : crc;
    len3 = 3'(n - 1);
    if (mask == 8'h00 || trl_lo != 16'h0E0E) begin
      push_ev(EV_FERR, 16'h0000, 8'h00, 1'b0);
    end else if (crc_field != crc) begin
      push_ev(EV_CERR, 16'h0000, 8'h00, 1'b0);
    end else begin
      push_ev(EV_OK, 16'h0000, 8'h00, 1'b0);
      for (int i = 0; i < n; i++) push_ev(EV_WORD, gray_m(pay[i]), mask, i == n - 1);
    end
    if (extra_hdr > 0) send_word(16'h1357);
    for (int i = 0; i < 2 + extra_hdr; i++) send_word(16'hE0E0);
    send_word({5'b00000, len3, mask});
    if (mask == 8'h00) return;
    for (int i = 0; i < n; i++) send_word(pay[i]);
    send_word(crc_field);
    send_word(16'h0E0E);
    send_word(trl_lo);
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 600) begin
      @(posedge clk_in); #1;
      n++;
    end
    check_val("queue_drained", 32'(exp_q.size()), 32'd0);
    idle(4);
  endtask

  initial begin
    int n;
    rst          = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_data  = 16'h0000;
    idle(3);
    check_val("rst_in_ready",  32'(bus.in_ready),    32'd1);
    check_val("rst_out_valid", 32'(bus.out_valid),   32'd0);
    check_val("rst_out_data",  32'(bus.out_data),    32'd0);
    check_val("rst_out_mask",  32'(bus.out_ch_mask), 32'd0);
    check_val("rst_out_last",  32'(bus.out_last),    32'd0);
    check_val("rst_pulses",    {29'd0, bus.crc_ok, bus.crc_err, bus.fmt_err}, 32'd0);
    rst = 1'b0;
    idle(2);

    // Single word, unicast
    pay[0] = 16'hA55A;
    send_frame(8'h01, 1, 0, 1'b0, 16'h0E0E);
    wait_empty();

    // Eight words with a toggling downstream
    ready_mode = 1;
    pay[0] = 16'h0123; pay[1] = 16'h4567; pay[2] = 16'h89AB; pay[3] = 16'hCDEF;
    pay[4] = 16'hFEDC; pay[5] = 16'hBA98; pay[6] = 16'h7654; pay[7] = 16'h3210;
    send_frame(8'h02, 8, 0, 1'b0, 16'h0E0E);
    wait_empty();
    ready_mode = 0;

    // Multicast frame back-to-back with a second frame (garbage and repeated headers first)
    pay[0] = 16'h1111; pay[1] = 16'h2222; pay[2] = 16'h3333; pay[3] = 16'h4444;
    send_frame(8'h0C, 4, 0, 1'b0, 16'h0E0E);
    pay[0] = 16'hBEEF; pay[1] = 16'h0F0F;
    send_frame(8'h81, 2, 2, 1'b0, 16'h0E0E);
    wait_empty();

    // CRC mismatch then a valid frame
    pay[0] = 16'h1234;
    send_frame(8'h01, 1, 0, 1'b1, 16'h0E0E);
    pay[0] = 16'h8000;
    send_frame(8'h40, 1, 0, 1'b0, 16'h0E0E);
    wait_empty();

    // Zero mask and bad trailer low word
    send_frame(8'h00, 1, 0, 1'b0, 16'h0E0E);
    pay[0] = 16'h5555;
    send_frame(8'h01, 1, 0, 1'b0, 16'h0E0F);
    wait_empty();

    // Idle mid-payload: error exactly on the 64th idle cycle
    push_ev(EV_FERR, 16'h0000, 8'h00, 1'b0);
    send_word(16'hE0E0);
    send_word(16'hE0E0);
    send_word(16'h0301);
    send_word(16'h1111);
    send_word(16'h2222);
    idle(63);
    check_val("timeout_not_early", 32'(bus.fmt_err), 32'd0);
    idle(1);
    check_val("timeout_fmt_err", 32'(bus.fmt_err), 32'd1);
    idle(2);
    wait_empty();
    pay[0] = 16'h00FF; pay[1] = 16'hFF00;
    send_frame(8'h20, 2, 0, 1'b0, 16'h0E0E);
    wait_empty();

    // Reset while draining against a stalled downstream
    ready_mode = 2;
    pay[0] = 16'hCAFE; pay[1] = 16'hD00D; pay[2] = 16'h7E57;
    send_frame(8'h10, 3, 0, 1'b0, 16'h0E0E);
    n = 0;
    while (bus.out_valid !== 1'b1 && n < 20) begin
      @(posedge clk_in); #1;
      n++;
    end
    check_val("drain_valid", 32'(bus.out_valid), 32'd1);
    check_val("drain_words_pending", 32'(exp_q.size()), 32'd3);
    rst = 1'b1;
    #1;
    check_val("rst_drain_valid", 32'(bus.out_valid), 32'd0);
    check_val("rst_drain_pulses", {29'd0, bus.crc_ok, bus.crc_err, bus.fmt_err}, 32'd0);
    exp_q.delete();
    idle(2);
    rst = 1'b0;
    ready_mode = 0;
    check_val("rst_drain_in_ready", 32'(bus.in_ready), 32'd1);
    pay[0] = 16'h0001; pay[1] = 16'h8421;
    send_frame(8'h03, 2, 0, 1'b0, 16'h0E0E);
    wait_empty();
    idle(10);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
